// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester one-entry buffers, round-robin grant, registered broadcast.
// Optional macro CDB_BYPASS_EN lets a result skip its buffer when all buffers are empty.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clear_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]  req_tag_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          cdb_en_out,
  output logic [ROB_WIDTH-1:0]          cdb_tag_out,
  output logic [DATA_WIDTH-1:0]         cdb_value_out,
  output logic [SRC_W-1:0]              cdb_src_out
);

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    int unsigned n;
    n = 32'(idx) + 32'd1;
    if (n >= NUM_REQ) n = 0;
    return SRC_W'(n);
  endfunction

  // Returns {found, index} of the first set bit at or above start, wrapping around.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                             input logic [SRC_W-1:0]   start);
    logic             found;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] ni;
    int unsigned      n;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      n = 32'(start) + k;
      if (n >= NUM_REQ) n = n - NUM_REQ;
      ni = SRC_W'(n);
      if (!found && vec[ni]) begin
        found = 1'b1;
        sel   = ni;
      end
    end
    return {found, sel};
  endfunction

  logic [ROB_WIDTH-1:0]  req_tag   [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_value [NUM_REQ];
  logic [NUM_REQ-1:0]    buf_valid;
  logic [ROB_WIDTH-1:0]  buf_tag   [NUM_REQ];
  logic [DATA_WIDTH-1:0] buf_value [NUM_REQ];
  logic [SRC_W-1:0]      rr_ptr;

  logic                  arb_en;
  logic [SRC_W:0]        grant_pick;
  logic                  grant_any;
  logic [SRC_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    keep;
  logic                  byp_any;
  logic [SRC_W-1:0]      byp_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_tag[g]   = req_tag_in[g*ROB_WIDTH +: ROB_WIDTH];
    assign req_value[g] = req_value_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Freeze and flush both suppress every grant and every accept.
  assign arb_en     = rdy_in && !clear_in;
  assign grant_pick = rr_pick(buf_valid, rr_ptr);
  assign grant_any  = arb_en && grant_pick[SRC_W];
  assign grant_idx  = grant_pick[SRC_W-1:0];

  always_comb begin
    grant         = '0;
    req_ready_out = '0;
    keep          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i]         = grant_any && (grant_idx == SRC_W'(i));
      req_ready_out[i] = arb_en && (!buf_valid[i] || grant[i]);
      // Tag 0 is accepted but dropped.
      keep[i]          = req_valid_in[i] && req_ready_out[i] && (req_tag[i] != '0);
    end
  end

`ifdef CDB_BYPASS_EN
  logic [SRC_W:0] byp_pick;
  assign byp_pick = rr_pick(keep, rr_ptr);
  assign byp_any  = !(|buf_valid) && byp_pick[SRC_W];
  assign byp_idx  = byp_pick[SRC_W-1:0];
`else
  assign byp_any  = 1'b0;
  assign byp_idx  = '0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_tag[i]   <= '0;
        buf_value[i] <= '0;
      end
    end else if (rdy_in) begin
      if (grant_any)    rr_ptr <= wrap_inc(grant_idx);
      else if (byp_any) rr_ptr <= wrap_inc(byp_idx);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (clear_in) begin
          buf_valid[i] <= 1'b0;
        end else if (keep[i] && !(byp_any && (byp_idx == SRC_W'(i)))) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= req_tag[i];
          buf_value[i] <= req_value[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_en_out    <= 1'b0;
      cdb_tag_out   <= '0;
      cdb_value_out <= '0;
      cdb_src_out   <= '0;
    end else if (rdy_in) begin
      if (grant_any) begin
        cdb_en_out    <= 1'b1;
        cdb_tag_out   <= buf_tag[grant_idx];
        cdb_value_out <= buf_value[grant_idx];
        cdb_src_out   <= grant_idx;
      end else if (byp_any) begin
        cdb_en_out    <= 1'b1;
        cdb_tag_out   <= req_tag[byp_idx];
        cdb_value_out <= req_value[byp_idx];
        cdb_src_out   <= byp_idx;
      end else begin
        cdb_en_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, no bypass); broadcasts are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic [2:0]  req_valid_in;
  logic [11:0] req_tag_in;
  logic [95:0] req_value_in;
  logic [2:0]  req_ready_out;
  logic        cdb_en_out;
  logic [3:0]  cdb_tag_out;
  logic [31:0] cdb_value_out;
  logic [1:0]  cdb_src_out;

  logic        tb_valid [3];
  logic [3:0]  tb_tag   [3];
  logic [31:0] tb_value [3];

  assign req_valid_in = {tb_valid[2], tb_valid[1], tb_valid[0]};
  assign req_tag_in   = {tb_tag[2], tb_tag[1], tb_tag[0]};
  assign req_value_in = {tb_value[2], tb_value[1], tb_value[0]};

  cdb_arbiter #(.NUM_REQ(3), .ROB_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_in      (clear_in),
    .req_valid_in  (req_valid_in),
    .req_tag_in    (req_tag_in),
    .req_value_in  (req_value_in),
    .req_ready_out (req_ready_out),
    .cdb_en_out    (cdb_en_out),
    .cdb_tag_out   (cdb_tag_out),
    .cdb_value_out (cdb_value_out),
    .cdb_src_out   (cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [1:0]  src;
  } bcast_t;

  bcast_t exp_q [$];
  bcast_t exp_b;
  int     errors = 0;
  int     checks = 0;
  logic   mon_rdy;
  logic   mon_rst;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] v, input logic [1:0] s);
    bcast_t b;
    b.tag   = t;
    b.value = v;
    b.src   = s;
    exp_q.push_back(b);
  endtask

  task automatic set_req(input logic [1:0] i, input logic v, input logic [3:0] t, input logic [31:0] d);
    tb_valid[i] = v;
    tb_tag[i]   = t;
    tb_value[i] = d;
  endtask

  task automatic clr_reqs();
    set_req(2'd0, 1'b0, 4'd0, 32'd0);
    set_req(2'd1, 1'b0, 4'd0, 32'd0);
    set_req(2'd2, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
  endtask

  // Every new broadcast (edge taken with rdy high, out of reset) must match the queue head.
  always @(posedge clk_in) begin
    mon_rdy = rdy_in;
    mon_rst = rst_in;
    #2;
    if (mon_rst && rst_in && mon_rdy && cdb_en_out) begin
      if (exp_q.size() == 0) begin
        chk("bcast_unexpected", 64'(cdb_en_out), 64'd0);
      end else begin
        exp_b = exp_q.pop_front();
        chk("bcast", 64'({cdb_tag_out, cdb_value_out, cdb_src_out}), 64'(exp_b));
      end
    end
  end

  initial begin
    clr_reqs();
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    repeat (2) tick();
    chk("reset_outs", 64'({cdb_en_out, cdb_tag_out, cdb_value_out, cdb_src_out}), 64'd0);
    chk("reset_ready", 64'(req_ready_out), 64'(3'b111));
    rst_in = 1'b1;

    // Single ALU request: latency two edges
    set_req(2'd0, 1'b1, 4'd5, 32'h0000_00AA);
    #1;
    chk("s1_ready", 64'(req_ready_out), 64'(3'b111));
    push(4'd5, 32'h0000_00AA, 2'd0);
    tick();
    clr_reqs();
    chk("s1_en_after_e1", 64'(cdb_en_out), 64'd0);
    tick();
    chk("s1_bcast_e2", 64'({cdb_en_out, cdb_tag_out, cdb_value_out, cdb_src_out}),
        64'({1'b1, 4'd5, 32'h0000_00AA, 2'd0}));
    tick();
    chk("s1_en_after_e3", 64'(cdb_en_out), 64'd0);

    // All three together with pointer 0
    do_reset();
    set_req(2'd0, 1'b1, 4'd1, 32'h1111_0001);
    set_req(2'd1, 1'b1, 4'd2, 32'h2222_0002);
    set_req(2'd2, 1'b1, 4'd3, 32'h3333_0003);
    #1;
    chk("s2_ready_empty", 64'(req_ready_out), 64'(3'b111));
    push(4'd1, 32'h1111_0001, 2'd0);
    push(4'd2, 32'h2222_0002, 2'd1);
    push(4'd3, 32'h3333_0003, 2'd2);
    tick();
    clr_reqs();
    #1;
    chk("s2_ready_g0", 64'(req_ready_out), 64'(3'b001));
    tick();
    chk("s2_src_b", 64'({cdb_en_out, cdb_src_out}), 64'({1'b1, 2'd0}));
    chk("s2_ready_g1", 64'(req_ready_out), 64'(3'b011));
    tick();
    chk("s2_src_c", 64'({cdb_en_out, cdb_src_out}), 64'({1'b1, 2'd1}));
    chk("s2_ready_g2", 64'(req_ready_out), 64'(3'b111));
    tick();
    chk("s2_src_d", 64'({cdb_en_out, cdb_src_out}), 64'({1'b1, 2'd2}));
    tick();
    chk("s2_idle", 64'(cdb_en_out), 64'd0);

    // Requester 0 streams 4,5,6 while requester 2 holds 7; pointer 0
    set_req(2'd0, 1'b1, 4'd4, 32'h4444_0004);
    set_req(2'd2, 1'b1, 4'd7, 32'h7777_0007);
    #1;
    chk("s3_ready_f0", 64'(req_ready_out), 64'(3'b111));
    push(4'd4, 32'h4444_0004, 2'd0);
    push(4'd7, 32'h7777_0007, 2'd2);
    push(4'd5, 32'h5555_0005, 2'd0);
    push(4'd6, 32'h6666_0006, 2'd0);
    tick();
    set_req(2'd2, 1'b0, 4'd0, 32'd0);
    set_req(2'd0, 1'b1, 4'd5, 32'h5555_0005);
    #1;
    chk("s3_ready_f1", 64'(req_ready_out), 64'(3'b011));
    tick();
    set_req(2'd0, 1'b1, 4'd6, 32'h6666_0006);
    #1;
    chk("s3_ready_f2", 64'(req_ready_out), 64'(3'b110));
    tick();
    chk("s3_ready_f3", 64'(req_ready_out), 64'(3'b111));
    tick();
    clr_reqs();
    #1;
    chk("s3_ready_f4", 64'(req_ready_out), 64'(3'b111));
    tick();
    chk("s3_last", 64'({cdb_en_out, cdb_tag_out}), 64'({1'b1, 4'd6}));
    tick();
    chk("s3_idle", 64'(cdb_en_out), 64'd0);

    // Freeze with one broadcast showing and two entries buffered; pointer 1
    set_req(2'd0, 1'b1, 4'd8,  32'h8888_0008);
    set_req(2'd1, 1'b1, 4'd9,  32'h9999_0009);
    set_req(2'd2, 1'b1, 4'd10, 32'hAAAA_000A);
    push(4'd9,  32'h9999_0009, 2'd1);
    push(4'd10, 32'hAAAA_000A, 2'd2);
    push(4'd8,  32'h8888_0008, 2'd0);
    tick();
    clr_reqs();
    tick();
    rdy_in = 1'b0;
    #1;
    chk("s4_ready_frozen", 64'(req_ready_out), 64'(3'b000));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s4_hold", 64'({cdb_en_out, cdb_tag_out, cdb_value_out, cdb_src_out}),
          64'({1'b1, 4'd9, 32'h9999_0009, 2'd1}));
    end
    rdy_in = 1'b1;
    tick();
    chk("s4_resume_src2", 64'({cdb_en_out, cdb_src_out}), 64'({1'b1, 2'd2}));
    tick();
    chk("s4_resume_src0", 64'({cdb_en_out, cdb_src_out}), 64'({1'b1, 2'd0}));
    tick();
    chk("s4_idle", 64'(cdb_en_out), 64'd0);

    // Flush with tags 2 and 3 buffered; pointer stays 1
    set_req(2'd0, 1'b1, 4'd2, 32'h0000_2222);
    set_req(2'd2, 1'b1, 4'd3, 32'h0000_3333);
    #1;
    chk("s5_ready_pre", 64'(req_ready_out), 64'(3'b111));
    tick();
    clr_reqs();
    clear_in = 1'b1;
    #1;
    chk("s5_ready_clear", 64'(req_ready_out), 64'(3'b000));
    tick();
    clear_in = 1'b0;
    chk("s5_en_after_clear", 64'(cdb_en_out), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("s5_no_bcast", 64'(cdb_en_out), 64'd0);
    end
    set_req(2'd0, 1'b1, 4'd11, 32'hB0B0_000B);
    set_req(2'd1, 1'b1, 4'd12, 32'hC0C0_000C);
    set_req(2'd2, 1'b1, 4'd13, 32'hD0D0_000D);
    push(4'd12, 32'hC0C0_000C, 2'd1);
    push(4'd13, 32'hD0D0_000D, 2'd2);
    push(4'd11, 32'hB0B0_000B, 2'd0);
    tick();
    clr_reqs();
    repeat (3) tick();
    tick();
    chk("s5_idle", 64'(cdb_en_out), 64'd0);

    // Tag 0 is accepted and dropped
    set_req(2'd1, 1'b1, 4'd0, 32'hDEAD_BEEF);
    #1;
    chk("s6_tag0_ready", 64'(req_ready_out), 64'(3'b111));
    tick();
    clr_reqs();
    for (int k = 0; k < 3; k++) begin
      chk("s6_tag0_no_bcast", 64'(cdb_en_out), 64'd0);
      tick();
    end

    // Asynchronous reset mid-stream; pointer 1
    set_req(2'd0, 1'b1, 4'd14, 32'hEEEE_000E);
    set_req(2'd1, 1'b1, 4'd15, 32'hFFFF_000F);
    set_req(2'd2, 1'b1, 4'd1,  32'h0101_0001);
    push(4'd15, 32'hFFFF_000F, 2'd1);
    tick();
    clr_reqs();
    tick();
    chk("s7_bcast_live", 64'({cdb_en_out, cdb_tag_out}), 64'({1'b1, 4'd15}));
    #2;
    rst_in = 1'b0;
    #1;
    chk("s7_async_outs", 64'({cdb_en_out, cdb_tag_out, cdb_value_out, cdb_src_out}), 64'd0);
    chk("s7_async_ready", 64'(req_ready_out), 64'(3'b111));
    tick();
    rst_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("s7_dropped", 64'(cdb_en_out), 64'd0);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
